uart_cmd_master: RTL and testbench



---
 rtl/uart_cmd_master.sv | 172 +++++++++++++++++
 tb/tb_uart_cmd_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: sends a 6-byte command frame through a uart_tx byte port and assembles the
// 5-byte reply from a uart_rx byte port. Define UART_CMD_MASTER_TIMEOUT_EN for the reply timeout.
module uart_cmd_master #(
    parameter logic [7:0]  END_BYTE       = 8'h0A,
    parameter int unsigned TIMEOUT_CYCLES = 24000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_rcv,
    input  logic [7:0]  rx_data
);

    typedef enum logic [2:0] {
        IDLE,
        TX_PUT,
        TX_BUSY,
        TX_DONE,
        RX_WAIT,
        RSP
    } state_t;

    state_t      state_q, state_d;
    logic [47:0] frame_q, frame_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [31:0] rsp_shift_q, rsp_shift_d;
    logic [31:0] rsp_data_q, rsp_data_d;

`ifdef UART_CMD_MASTER_TIMEOUT_EN
    // The counter reads 0 in the cycle after a strobe, so matching TIMEOUT_CYCLES-2 lands the
    // rsp_valid pulse exactly TIMEOUT_CYCLES cycles after the last byte.
    localparam int unsigned   CntW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 2);

    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        tx_idx_d    = tx_idx_q;
        rx_idx_d    = rx_idx_q;
        rsp_shift_d = rsp_shift_q;
        rsp_data_d  = rsp_data_q;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        timeout_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    frame_d  = {req_cmd, req_data, END_BYTE};
                    tx_idx_d = 3'd0;
                    state_d  = TX_PUT;
                end
            end

            TX_PUT: begin
                if (tx_ready) begin
                    state_d = TX_BUSY;
                end
            end

            // uart_tx may keep ready high for a couple of cycles after start; wait for it to drop
            TX_BUSY: begin
                if (!tx_ready) begin
                    state_d = TX_DONE;
                end
            end

            TX_DONE: begin
                if (tx_ready) begin
                    frame_d  = {frame_q[39:0], 8'h00};
                    tx_idx_d = tx_idx_q + 3'd1;
                    if (tx_idx_q == 3'd5) begin
                        rsp_shift_d = 32'h0;
                        rx_idx_d    = 3'd0;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
                        tmo_cnt_d   = '0;
`endif
                        state_d     = RX_WAIT;
                    end else begin
                        state_d = TX_PUT;
                    end
                end
            end

            RX_WAIT: begin
                if (rx_rcv) begin
                    if (rx_idx_q < 3'd4) begin
                        rsp_shift_d = {rsp_shift_q[23:0], rx_data};
                    end
                    rx_idx_d = rx_idx_q + 3'd1;
                    if (rx_idx_q == 3'd4) begin
                        rsp_data_d = rsp_shift_q;
                        state_d    = RSP;
                    end
`ifdef UART_CMD_MASTER_TIMEOUT_EN
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == CntLast) begin
                    rsp_data_d = rsp_shift_q;
                    timeout_d  = 1'b1;
                    state_d    = RSP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end

            RSP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            frame_q     <= 48'h0;
            tx_idx_q    <= 3'd0;
            rx_idx_q    <= 3'd0;
            rsp_shift_q <= 32'h0;
            rsp_data_q  <= 32'h0;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            tx_idx_q    <= tx_idx_d;
            rx_idx_q    <= rx_idx_d;
            rsp_shift_q <= rsp_shift_d;
            rsp_data_q  <= rsp_data_d;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Start is gated by reset so an abandoned frame can never launch another byte.
    assign tx_start  = (state_q == TX_PUT) && tx_ready && !reset;
    assign tx_data   = frame_q[47:40];
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RSP);
    assign rsp_data  = rsp_data_q;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
    assign rsp_timeout = timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_master.sv
// Self-checking bench for uart_cmd_master: uart_tx/uart_rx byte-port models plus a frame-level
// reference model. Timeout section follows UART_CMD_MASTER_TIMEOUT_EN.
module tb_uart_cmd_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_rcv;
    logic [7:0]  rx_data;

    int total = 0;
    int bad   = 0;

    int         cycle     = 0;
    int         txCnt     = 0;
    int         lastStart = -1000;
    int         gapErr    = 0;
    int         rspCycle  = -1;
    int         frameBase = 0;
    logic [7:0] txLog[$];
    int         startCycles[$];
    int         accLog[$];

    uart_cmd_master #(
        .END_BYTE      (8'h0A),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_rcv     (rx_rcv),
        .rx_data    (rx_data)
    );

    always #5 clk = ~clk;

    // uart_tx model: ready falls 2 cycles after start and returns after a 40-cycle byte time.
    assign tx_ready = (txCnt <= 2);

    always @(negedge clk) begin
        cycle = cycle + 1;
        if (tx_start) begin
            if (cycle - lastStart < 40) gapErr = gapErr + 1;
            lastStart = cycle;
            txLog.push_back(tx_data);
            startCycles.push_back(cycle);
            txCnt = 1;
        end else if (txCnt != 0) begin
            txCnt = (txCnt == 40) ? 0 : txCnt + 1;
        end
        if (req_valid && req_ready && !reset) accLog.push_back(cycle);
        if (rsp_valid) rspCycle = cycle;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got hang required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitTxIdle();
        int n = 0;
        while (txCnt != 0 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("tx_idle_wait", 32'(txCnt), 32'd0);
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] data, input bit hold);
        int n = 0;
        waitTxIdle();
        frameBase = txLog.size();
        req_cmd   = cmd;
        req_data  = data;
        req_valid = 1'b1;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        checkOutput("req_ready_wait", 32'(req_ready), 32'd1);
        tick();
        if (!hold) req_valid = 1'b0;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Reference frame: cmd, the operand MSB-first, then the end byte.
    task automatic runFrame(input logic [7:0] cmd, input logic [31:0] data, input int base, input bit stray);
        logic [7:0] exp [6];
        int n = 0;
        exp[0] = cmd;
        for (int i = 0; i < 4; i++) exp[i+1] = 8'((data >> (24 - 8*i)) & 32'hFF);
        exp[5] = 8'h0A;
        while (txLog.size() < base + 6 && n < 600) begin
            if (stray && n == 20) begin
                rx_rcv  = 1'b1;
                rx_data = 8'hFF;
            end else begin
                rx_rcv = 1'b0;
            end
            tick();
            n++;
        end
        rx_rcv = 1'b0;
        checkOutput("tx_count", 32'(txLog.size() - base), 32'd6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("tx_byte%0d", i), 32'(txLog[base+i]), 32'(exp[i]));
        end
        checkOutput("first_start_latency", 32'(startCycles[base] - accLog[accLog.size()-1]), 32'd1);
        waitTxIdle();
        tick();
    endtask

    task automatic sendReply(input logic [39:0] reply, input int count);
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            rx_rcv  = 1'b1;
            rx_data = 8'((reply >> (32 - 8*i)) & 40'hFF);
            tick();
            rx_rcv = 1'b0;
        end
    endtask

    task automatic checkReply(input logic [39:0] reply);
        logic [31:0] exp = 32'h0;
        for (int i = 0; i < 4; i++) exp = exp * 256 + 32'((reply >> (32 - 8*i)) & 40'hFF);
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_data", rsp_data, exp);
        checkOutput("rsp_timeout", 32'(rsp_timeout), 32'd0);
        checkOutput("req_ready_in_rsp", 32'(req_ready), 32'd0);
        checkOutput("busy_in_rsp", 32'(busy), 32'd1);
        tick();
        checkOutput("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
        checkOutput("rsp_data_held", rsp_data, exp);
        checkOutput("req_ready_after", 32'(req_ready), 32'd1);
        checkOutput("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
        checkOutput({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        checkOutput({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        checkOutput({tag, "_rsp_data"}, rsp_data, 32'd0);
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [31:0] data;
        logic [31:0] d2;
        logic [39:0] reply;
        logic [31:0] hi;
        logic [31:0] lo;
        int          acc0;
        int          base2;
        int          k;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_cmd   = 8'h00;
        req_data  = 32'h0;
        rx_rcv    = 1'b0;
        rx_data   = 8'h00;
        repeat (3) tick();
        checkResetValues("reset");
        reset = 1'b0;

        // Stray byte in IDLE, then the ADDR echo with another stray during TX.
        rx_rcv  = 1'b1;
        rx_data = 8'hFF;
        tick();
        rx_rcv = 1'b0;
        checkOutput("stray_idle_busy", 32'(busy), 32'd0);
        applyStimulus(8'h01, 32'h12345678, 1'b0);
        runFrame(8'h01, 32'h12345678, frameBase, 1'b1);
        sendReply(40'h12345678_00, 5);
        checkReply(40'h12345678_00);

        // Backpressure: a CONST request waits behind an active WRITE.
        d2 = 32'hCAFE0007;
        applyStimulus(8'h03, 32'hA5A55A5A, 1'b1);
        acc0     = accLog.size();
        req_cmd  = 8'h07;
        req_data = d2;
        runFrame(8'h03, 32'hA5A55A5A, frameBase, 1'b0);
        sendReply(40'h01020304_00, 5);
        checkOutput("no_accept_during_frame", 32'(accLog.size()), 32'(acc0));
        checkReply(40'h01020304_00);
        base2 = txLog.size();
        tick();
        req_valid = 1'b0;
        checkOutput("second_accept_count", 32'(accLog.size()), 32'(acc0 + 1));
        checkOutput("second_accept_cycle", 32'(accLog[accLog.size()-1] - rspCycle), 32'd1);
        runFrame(8'h07, d2, base2, 1'b0);
        sendReply(40'h00000103_00, 5);
        checkReply(40'h00000103_00);

        for (int it = 0; it < 4; it++) begin
            cmd   = 8'($urandom_range(1, 7));
            data  = $urandom;
            hi    = $urandom;
            lo    = $urandom;
            reply = {hi, lo[7:0]};
            applyStimulus(cmd, data, 1'b0);
            runFrame(cmd, data, frameBase, 1'b0);
            sendReply(reply, 5);
            checkReply(reply);
        end

        // Reset after the third start abandons the frame.
        applyStimulus(8'h04, 32'h0BADF00D, 1'b0);
        k = 0;
        while (txLog.size() < frameBase + 3 && k < 300) begin
            tick();
            k++;
        end
        reset   = 1'b1;
        rx_rcv  = 1'b1;
        rx_data = 8'h55;
        tick();
        reset  = 1'b0;
        rx_rcv = 1'b0;
        checkResetValues("midreset");
        tick();
        checkOutput("starts_before_reset", 32'(txLog.size() - frameBase), 32'd3);
        applyStimulus(8'h02, 32'h89ABCDEF, 1'b0);
        runFrame(8'h02, 32'h89ABCDEF, frameBase, 1'b0);
        sendReply(40'hDEADBEEF_77, 5);
        checkReply(40'hDEADBEEF_77);

        // Partial reply followed by silence.
        applyStimulus(8'h05, 32'h00000010, 1'b0);
        runFrame(8'h05, 32'h00000010, frameBase, 1'b0);
        sendReply(40'hABCD000000, 2);
        k = 1;
        while (!rsp_valid && k < 1200) begin
            tick();
            k++;
        end
`ifdef UART_CMD_MASTER_TIMEOUT_EN
        checkOutput("timeout_latency", 32'(k), 32'd1000);
        checkOutput("timeout_flag", 32'(rsp_timeout), 32'd1);
        checkOutput("timeout_data", rsp_data, 32'h0000ABCD);
        tick();
        checkOutput("timeout_back_idle", 32'(busy), 32'd0);
`else
        checkOutput("no_timeout_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("stays_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("reset_exits_rx", 32'(busy), 32'd0);
`endif

        checkOutput("start_spacing", 32'(gapErr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
